// File: rtl/clock_display_scanner.sv
// clock_display_scanner: snapshots time/date/timer values once per frame and
// scans them onto a 6-digit common-anode 7-segment display.
// Ports: clk, reset (sync, active-high); page_sel, hr, min, sec, AM_mode,
//   AM_PM, day, month, year, timer_min_left, timer_sec_left, blink_mask in;
//   an (active-low, bit0 = leftmost), seg (gfedcba, active-low), dp out.
module clock_display_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  page_sel,
  input  logic [5:0]  hr,
  input  logic [5:0]  min,
  input  logic [5:0]  sec,
  input  logic        AM_mode,
  input  logic        AM_PM,
  input  logic [4:0]  day,
  input  logic [3:0]  month,
  input  logic [11:0] year,
  input  logic [5:0]  timer_min_left,
  input  logic [5:0]  timer_sec_left,
  input  logic [2:0]  blink_mask,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [3:0] SYM_DASH  = 4'd10;
  localparam logic [3:0] SYM_BLANK = 4'd11;

  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit_idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          scan_last;
  logic          frame_end;

  assign scan_last = (scan_cnt == SCAN_LAST);
  assign frame_end = scan_last && (digit_idx == 3'd5);

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (scan_last) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      if (frame_end) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // Snapshot taken on the last cycle of a frame so a whole frame is
  // drawn from one consistent set of values.
  logic [1:0]  pg_q;
  logic [5:0]  hr_q;
  logic [5:0]  min_q;
  logic [5:0]  sec_q;
  logic        am_mode_q;
  logic        am_pm_q;
  logic [4:0]  day_q;
  logic [3:0]  month_q;
  logic [11:0] year_q;
  logic [5:0]  tmin_q;
  logic [5:0]  tsec_q;
  logic [2:0]  mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pg_q      <= '0;
      hr_q      <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      am_mode_q <= 1'b0;
      am_pm_q   <= 1'b0;
      day_q     <= '0;
      month_q   <= '0;
      year_q    <= '0;
      tmin_q    <= '0;
      tsec_q    <= '0;
      mask_q    <= '0;
    end else if (frame_end) begin
      pg_q      <= page_sel;
      hr_q      <= hr;
      min_q     <= min;
      sec_q     <= sec;
      am_mode_q <= AM_mode;
      am_pm_q   <= AM_PM;
      day_q     <= day;
      month_q   <= month;
      year_q    <= year;
      tmin_q    <= timer_min_left;
      tsec_q    <= timer_sec_left;
      mask_q    <= blink_mask;
    end
  end

  // {tens, units}; inputs never exceed 99 after the year fold.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] s);
    logic [6:0] c;
    case (s)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      4'd10:   c = 7'h3F;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  logic [7:0] hr_b;
  logic [7:0] min_b;
  logic [7:0] sec_b;
  logic [7:0] day_b;
  logic [7:0] mon_b;
  logic [7:0] yr_b;
  logic [7:0] tm_b;
  logic [7:0] ts_b;

  assign hr_b  = to_bcd({1'b0, hr_q});
  assign min_b = to_bcd({1'b0, min_q});
  assign sec_b = to_bcd({1'b0, sec_q});
  assign day_b = to_bcd({2'b0, day_q});
  assign mon_b = to_bcd({3'b0, month_q});
  assign yr_b  = to_bcd(7'(year_q % 12'd100));
  assign tm_b  = to_bcd({1'b0, tmin_q});
  assign ts_b  = to_bcd({1'b0, tsec_q});

  // syms[i] / dps[i] describe digit i of the current page.
  logic [5:0][3:0] syms;
  logic [5:0]      dps;

  always_comb begin
    syms = {6{SYM_BLANK}};
    dps  = 6'b0;
    unique case (pg_q)
      2'd0: begin
        syms[0] = (am_mode_q && hr_b[7:4] == 4'd0) ? SYM_BLANK
                                                   : hr_b[7:4];
        syms[1] = hr_b[3:0];
        syms[2] = min_b[7:4];
        syms[3] = min_b[3:0];
        syms[4] = sec_b[7:4];
        syms[5] = sec_b[3:0];
        dps     = {am_mode_q & am_pm_q, 5'b01010};
      end
      2'd1: begin
        syms[0] = day_b[7:4];
        syms[1] = day_b[3:0];
        syms[2] = mon_b[7:4];
        syms[3] = mon_b[3:0];
        syms[4] = yr_b[7:4];
        syms[5] = yr_b[3:0];
        dps     = 6'b001010;
      end
      2'd2: begin
        syms[2] = tm_b[7:4];
        syms[3] = tm_b[3:0];
        syms[4] = ts_b[7:4];
        syms[5] = ts_b[3:0];
        dps     = 6'b001000;
      end
      2'd3: begin
        syms = {6{SYM_DASH}};
      end
    endcase
  end

  logic [3:0] sym;
  logic       dp_on;
  logic [5:0] an_nxt;
  logic       grp_mask;
  logic       blank;

  always_comb begin
    sym      = SYM_BLANK;
    dp_on    = 1'b0;
    an_nxt   = 6'h3F;
    grp_mask = 1'b0;
    case (digit_idx)
      3'd0: begin
        sym = syms[0]; dp_on = dps[0];
        an_nxt = 6'h3E; grp_mask = mask_q[2];
      end
      3'd1: begin
        sym = syms[1]; dp_on = dps[1];
        an_nxt = 6'h3D; grp_mask = mask_q[2];
      end
      3'd2: begin
        sym = syms[2]; dp_on = dps[2];
        an_nxt = 6'h3B; grp_mask = mask_q[1];
      end
      3'd3: begin
        sym = syms[3]; dp_on = dps[3];
        an_nxt = 6'h37; grp_mask = mask_q[1];
      end
      3'd4: begin
        sym = syms[4]; dp_on = dps[4];
        an_nxt = 6'h2F; grp_mask = mask_q[0];
      end
      3'd5: begin
        sym = syms[5]; dp_on = dps[5];
        an_nxt = 6'h1F; grp_mask = mask_q[0];
      end
      default: ;
    endcase
  end

  // Blanking only kills segments; the anode keeps scanning.
  assign blank = blink_phase & grp_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 6'h3F;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= blank ? 7'h7F : seg_code(sym);
      dp  <= blank | ~dp_on;
    end
  end

endmodule
